// File: rtl/loop_cnt_stack.sv
// Loop counter stack: LIFO of loop counts with in-place decrement of the top entry.
// Outputs are pure decodes of the registered level/entry state, so they read back with zero latency.
module loop_cnt_stack #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             DSPCLK,
  input  logic             T_RST,
  input  logic             CNS_CKenb,
  input  logic [WIDTH-1:0] CNTin,
  input  logic             PushCNT_EN,
  input  logic             PopCNT_EN,
  input  logic             DecCNT_EN,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] TopCNT,
  output logic [LW-1:0]    CNT_level,
  output logic             CNT_empty,
  output logic             CNT_full,
  output logic             CNT_has1,
  output logic             TopCE,
  output logic             CNT_ovf,
  output logic             CNT_unf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    level;
  logic [LW-1:0]    lvl_m1;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    wr_idx;
  logic             ovf, unf;

  logic op_en, empty, full;
  logic do_push_new, do_replace, do_pop, do_dec;
  logic ovf_set, unf_set;

  assign lvl_m1  = level - LW'(1);
  assign top_idx = lvl_m1[IW-1:0];
  assign wr_idx  = level[IW-1:0];

  assign op_en = ~CNS_CKenb;
  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // Push+pop on an empty stack degenerates to a plain push; dec only acts when alone.
  assign do_push_new = op_en & PushCNT_EN & (~PopCNT_EN | empty) & ~full;
  assign do_replace  = op_en & PushCNT_EN & PopCNT_EN & ~empty;
  assign do_pop      = op_en & PopCNT_EN & ~PushCNT_EN & ~empty;
  assign do_dec      = op_en & DecCNT_EN & ~PushCNT_EN & ~PopCNT_EN & ~empty;
  assign ovf_set     = op_en & PushCNT_EN & ~PopCNT_EN & full;
  assign unf_set     = op_en & ~PushCNT_EN & (PopCNT_EN | DecCNT_EN) & empty;

  always_ff @(posedge DSPCLK) begin
    if (T_RST) begin
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push_new) begin
        mem[wr_idx] <= CNTin;
        level       <= level + LW'(1);
      end else if (do_replace) begin
        mem[top_idx] <= CNTin;
      end else if (do_pop) begin
        level <= lvl_m1;
      end else if (do_dec) begin
        mem[top_idx] <= mem[top_idx] - WIDTH'(1);
      end
      // A new error event outranks a clear in the same cycle.
      ovf <= ovf_set | (ovf & ~ErrClr);
      unf <= unf_set | (unf & ~ErrClr);
    end
  end

  assign TopCNT    = empty ? '0 : mem[top_idx];
  assign CNT_level = level;
  assign CNT_empty = empty;
  assign CNT_full  = full;
  assign CNT_has1  = (level == LW'(1));
  assign TopCE     = ~empty & (mem[top_idx] == WIDTH'(1));
  assign CNT_ovf   = ovf;
  assign CNT_unf   = unf;

endmodule

// File: tb/tb_loop_cnt_stack.sv
// Directed-vector bench for loop_cnt_stack: default 14x4 instance (A) and an 8x7 instance (B).
module tb_loop_cnt_stack;

  logic DSPCLK;
  initial DSPCLK = 1'b0;
  always #5 DSPCLK = ~DSPCLK;

  // Instance A: WIDTH=14, DEPTH=4
  logic        a_rst, a_ck, a_push, a_pop, a_dec, a_clr;
  logic [13:0] a_din, a_top;
  logic [2:0]  a_lvl;
  logic        a_e, a_f, a_h, a_c, a_o, a_u;

  // Instance B: WIDTH=8, DEPTH=7
  logic        b_rst, b_ck, b_push, b_pop, b_dec, b_clr;
  logic [7:0]  b_din, b_top;
  logic [2:0]  b_lvl;
  logic        b_e, b_f, b_h, b_c, b_o, b_u;

  loop_cnt_stack dut_a (
    .DSPCLK(DSPCLK), .T_RST(a_rst), .CNS_CKenb(a_ck), .CNTin(a_din),
    .PushCNT_EN(a_push), .PopCNT_EN(a_pop), .DecCNT_EN(a_dec), .ErrClr(a_clr),
    .TopCNT(a_top), .CNT_level(a_lvl), .CNT_empty(a_e), .CNT_full(a_f),
    .CNT_has1(a_h), .TopCE(a_c), .CNT_ovf(a_o), .CNT_unf(a_u)
  );

  loop_cnt_stack #(.WIDTH(8), .DEPTH(7)) dut_b (
    .DSPCLK(DSPCLK), .T_RST(b_rst), .CNS_CKenb(b_ck), .CNTin(b_din),
    .PushCNT_EN(b_push), .PopCNT_EN(b_pop), .DecCNT_EN(b_dec), .ErrClr(b_clr),
    .TopCNT(b_top), .CNT_level(b_lvl), .CNT_empty(b_e), .CNT_full(b_f),
    .CNT_has1(b_h), .TopCE(b_c), .CNT_ovf(b_o), .CNT_unf(b_u)
  );

  typedef struct {
    bit          inst;
    bit          rst, ck, push, pop, dec, clr;
    logic [31:0] din;
    logic [31:0] top;
    int          lvl;
    logic [5:0]  fl;   // {empty, full, has1, topce, ovf, unf}
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input bit inst, input bit rst, input bit ck, input bit push,
                     input bit pop, input bit dec, input bit clr, input logic [31:0] din,
                     input logic [31:0] top, input int lvl, input logic [5:0] fl);
    vec_t v;
    v.inst = inst; v.rst = rst; v.ck = ck; v.push = push; v.pop = pop;
    v.dec = dec; v.clr = clr; v.din = din; v.top = top; v.lvl = lvl; v.fl = fl;
    tbl.push_back(v);
  endtask

  task automatic idle_all();
    a_rst = 0; a_ck = 0; a_push = 0; a_pop = 0; a_dec = 0; a_clr = 0; a_din = '0;
    b_rst = 0; b_ck = 0; b_push = 0; b_pop = 0; b_dec = 0; b_clr = 0; b_din = '0;
  endtask

  task automatic apply(input vec_t v, input string name);
    logic [31:0] top_act;
    int          lvl_act;
    logic [5:0]  fl_act;
    idle_all();
    if (v.inst == 1'b0) begin
      a_rst = v.rst; a_ck = v.ck; a_push = v.push; a_pop = v.pop;
      a_dec = v.dec; a_clr = v.clr; a_din = v.din[13:0];
    end else begin
      b_rst = v.rst; b_ck = v.ck; b_push = v.push; b_pop = v.pop;
      b_dec = v.dec; b_clr = v.clr; b_din = v.din[7:0];
    end
    @(posedge DSPCLK);
    #1;
    if (v.inst == 1'b0) begin
      top_act = 32'(a_top); lvl_act = int'(a_lvl);
      fl_act  = {a_e, a_f, a_h, a_c, a_o, a_u};
    end else begin
      top_act = 32'(b_top); lvl_act = int'(b_lvl);
      fl_act  = {b_e, b_f, b_h, b_c, b_o, b_u};
    end
    n_vec++;
    if (top_act !== v.top || lvl_act != v.lvl || fl_act !== v.fl) begin
      n_bad++;
      $display("FAIL %s: got top=%0h lvl=%0d flags=%b, expected top=%0h lvl=%0d flags=%b",
               name, top_act, lvl_act, fl_act, v.top, v.lvl, v.fl);
    end
  endtask

  initial begin
    idle_all();
    a_rst = 1; b_rst = 1;

    // ---- Instance A (14-bit, depth 4) ----
    //  inst rst ck push pop dec clr din      top      lvl flags(E F H C O U)
    add(0, 1, 0, 1, 0, 0, 0, 32'h5,    32'h0,    0, 6'b100000); // reset, push discarded
    add(0, 0, 0, 1, 0, 0, 0, 32'h5,    32'h5,    1, 6'b001000);
    add(0, 0, 0, 1, 0, 0, 0, 32'h9,    32'h9,    2, 6'b000000);
    add(0, 0, 0, 1, 0, 0, 0, 32'h3,    32'h3,    3, 6'b000000);
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h9,    2, 6'b000000);
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h5,    1, 6'b001000);
    add(0, 0, 0, 1, 0, 0, 0, 32'h11,   32'h11,   2, 6'b000000);
    add(0, 0, 0, 1, 0, 0, 0, 32'h22,   32'h22,   3, 6'b000000);
    add(0, 0, 0, 1, 0, 0, 0, 32'h33,   32'h33,   4, 6'b010000); // full
    add(0, 0, 0, 1, 0, 0, 0, 32'h7,    32'h33,   4, 6'b010010); // overflow
    add(0, 0, 0, 1, 1, 0, 0, 32'h2A,   32'h2A,   4, 6'b010010); // replace on full
    add(0, 0, 0, 0, 0, 0, 1, 32'h0,    32'h2A,   4, 6'b010000);
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,    32'h0,    0, 6'b100000);
    add(0, 0, 0, 1, 0, 0, 0, 32'h2,    32'h2,    1, 6'b001000);
    add(0, 0, 0, 0, 0, 1, 0, 32'h0,    32'h1,    1, 6'b001100); // last iteration
    add(0, 0, 0, 0, 0, 1, 0, 32'h0,    32'h0,    1, 6'b001000);
    add(0, 0, 0, 0, 0, 1, 0, 32'h0,    32'h3FFF, 1, 6'b001000); // wrap
    add(0, 0, 0, 1, 0, 1, 0, 32'h4,    32'h4,    2, 6'b000000); // dec ignored with push
    add(0, 0, 0, 0, 1, 1, 0, 32'h0,    32'h3FFF, 1, 6'b001000); // dec ignored with pop
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    0, 6'b100000);
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    0, 6'b100001); // underflow
    add(0, 0, 0, 0, 0, 1, 0, 32'h0,    32'h0,    0, 6'b100001);
    add(0, 0, 0, 1, 1, 0, 0, 32'h6,    32'h6,    1, 6'b001001); // push+pop on empty
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    0, 6'b100001);
    add(0, 0, 0, 0, 1, 0, 1, 32'h0,    32'h0,    0, 6'b100001); // error beats clear
    add(0, 0, 0, 0, 0, 0, 1, 32'h0,    32'h0,    0, 6'b100000);
    add(0, 0, 0, 1, 0, 0, 0, 32'h8,    32'h8,    1, 6'b001000);
    add(0, 0, 1, 1, 0, 0, 0, 32'h9,    32'h8,    1, 6'b001000); // disabled
    add(0, 0, 1, 0, 1, 0, 0, 32'h0,    32'h8,    1, 6'b001000);
    add(0, 0, 1, 0, 0, 1, 0, 32'h0,    32'h8,    1, 6'b001000);
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    0, 6'b100000);
    add(0, 0, 1, 0, 1, 0, 0, 32'h0,    32'h0,    0, 6'b100000); // no unf when disabled
    add(0, 0, 1, 0, 0, 1, 0, 32'h0,    32'h0,    0, 6'b100000);
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    0, 6'b100001);
    add(0, 0, 1, 0, 0, 0, 1, 32'h0,    32'h0,    0, 6'b100000); // clear while disabled
    add(0, 0, 0, 1, 0, 0, 0, 32'h1,    32'h1,    1, 6'b001100);
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    0, 6'b100000);
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    0, 6'b100001);
    add(0, 1, 0, 1, 0, 0, 0, 32'h7,    32'h0,    0, 6'b100000); // reset beats push

    // ---- Instance B (8-bit, depth 7) ----
    add(1, 1, 0, 0, 0, 0, 0, 32'h0,    32'h0,    0, 6'b100000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h5,    32'h5,    1, 6'b001000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h9,    32'h9,    2, 6'b000000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h3,    32'h3,    3, 6'b000000);
    add(1, 0, 0, 0, 1, 0, 0, 32'h0,    32'h9,    2, 6'b000000);
    add(1, 0, 0, 0, 1, 0, 0, 32'h0,    32'h5,    1, 6'b001000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h11,   32'h11,   2, 6'b000000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h22,   32'h22,   3, 6'b000000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h33,   32'h33,   4, 6'b000000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h44,   32'h44,   5, 6'b000000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h55,   32'h55,   6, 6'b000000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h66,   32'h66,   7, 6'b010000); // full at 7
    add(1, 0, 0, 1, 0, 0, 0, 32'h7,    32'h66,   7, 6'b010010);
    add(1, 0, 0, 1, 1, 0, 0, 32'h2A,   32'h2A,   7, 6'b010010);
    add(1, 0, 0, 0, 0, 0, 1, 32'h0,    32'h2A,   7, 6'b010000);
    add(1, 1, 0, 0, 0, 0, 0, 32'h0,    32'h0,    0, 6'b100000);
    add(1, 0, 0, 1, 0, 0, 0, 32'h2,    32'h2,    1, 6'b001000);
    add(1, 0, 0, 0, 0, 1, 0, 32'h0,    32'h1,    1, 6'b001100);
    add(1, 0, 0, 0, 0, 1, 0, 32'h0,    32'h0,    1, 6'b001000);
    add(1, 0, 0, 0, 0, 1, 0, 32'h0,    32'hFF,   1, 6'b001000); // wrap to 0xFF

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Hand-written fill/drain sequence on B: reset, push 7 distinct values, then pop back.
    begin
      vec_t v;
      v.inst = 1; v.ck = 0; v.dec = 0; v.clr = 0; v.pop = 0; v.push = 0;
      v.rst = 1; v.din = 0; v.top = 0; v.lvl = 0; v.fl = 6'b100000;
      apply(v, "fill_rst");
      v.rst = 0;
      for (int k = 1; k <= 7; k++) begin
        v.push = 1; v.pop = 0; v.din = 32'(8'hA0 + k); v.top = v.din; v.lvl = k;
        v.fl = {1'b0, k == 7, k == 1, 1'b0, 1'b0, 1'b0};
        apply(v, $sformatf("fill_push%0d", k));
      end
      for (int k = 6; k >= 0; k--) begin
        v.push = 0; v.pop = 1; v.din = 0; v.lvl = k;
        v.top = (k == 0) ? 32'h0 : 32'(8'hA0 + k);
        v.fl = {k == 0, 1'b0, k == 1, 1'b0, 1'b0, 1'b0};
        apply(v, $sformatf("drain_pop%0d", k));
      end
    end

    idle_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
